// File: rtl/dcache_pkg.sv
// Shared types and address-field helpers for the direct-mapped write-through data cache.
// Default geometry: 32-bit addresses, 16 lines of 4 words.
package dcache_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_REFILL = 2'd1,
        ST_WRITE  = 2'd2,
        ST_RESP   = 2'd3
    } state_t;

    localparam int DC_ADDR_W = 32;
    localparam int DC_DATA_W = 32;
    localparam int DC_LINES  = 16;
    localparam int DC_WORDS  = 4;
    localparam int DC_OFF_W  = $clog2(DC_WORDS);
    localparam int DC_IDX_W  = $clog2(DC_LINES);
    localparam int DC_TAG_W  = DC_ADDR_W - DC_IDX_W - DC_OFF_W - 2;

    typedef enum logic [1:0] {
        FLD_WORD  = 2'd0,
        FLD_INDEX = 2'd1,
        FLD_TAG   = 2'd2
    } addr_fld_t;

    // Extracts the word, index or tag field of a byte address for a given geometry;
    // the caller casts the result down to the field width.
    function automatic logic [63:0] addr_field(input logic [63:0] addr,
                                               input addr_fld_t  fld,
                                               input int         off_w,
                                               input int         idx_w);
        logic [63:0] res;
        case (fld)
            FLD_WORD:  res = (addr >> 2) & ((64'd1 << off_w) - 64'd1);
            FLD_INDEX: res = (addr >> (2 + off_w)) & ((64'd1 << idx_w) - 64'd1);
            default:   res = addr >> (2 + off_w + idx_w);
        endcase
        return res;
    endfunction

endpackage

// File: rtl/dcache_array.sv
// Tag, valid and data storage for the data cache: combinational read port,
// one word-write port, a tag/valid write strobe and async clear of all valid bits.
module dcache_array
    import dcache_pkg::*;
#(
    parameter int LINES  = DC_LINES,
    parameter int WORDS  = DC_WORDS,
    parameter int TAG_W  = DC_TAG_W,
    parameter int DATA_W = DC_DATA_W,
    localparam int IDX_W = $clog2(LINES),
    localparam int OFF_W = $clog2(WORDS)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [IDX_W-1:0]  rd_index,
    input  logic [OFF_W-1:0]  rd_word,
    output logic [TAG_W-1:0]  rd_tag,
    output logic              rd_valid,
    output logic [DATA_W-1:0] rd_data,
    input  logic              word_we,
    input  logic [IDX_W-1:0]  wr_index,
    input  logic [OFF_W-1:0]  wr_word,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              tag_we,
    input  logic [IDX_W-1:0]  tag_index,
    input  logic [TAG_W-1:0]  tag_wdata
);

    logic [TAG_W-1:0]  tags  [LINES];
    logic [DATA_W-1:0] words [LINES*WORDS];
    logic [LINES-1:0]  valid;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid <= '0;
        end else if (tag_we) begin
            valid[tag_index] <= 1'b1;
        end
    end

    // Tag and data contents are meaningless while the valid bit is clear, so they carry no reset.
    always_ff @(posedge clk) begin
        if (tag_we) begin
            tags[tag_index] <= tag_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (word_we) begin
            words[{wr_index, wr_word}] <= wr_data;
        end
    end

    assign rd_tag   = tags[rd_index];
    assign rd_valid = valid[rd_index];
    assign rd_data  = words[{rd_index, rd_word}];

endmodule

// File: rtl/dcache_ctrl.sv
// Direct-mapped, write-through, no-write-allocate data cache controller.
// Optional DCACHE_STATS_EN adds saturating hit_count/miss_count outputs.
//
//  state  | meaning
//  IDLE   | serve read hits; decode misses and stores
//  REFILL | fetch WORDS beats of the missing line from memory
//  WRITE  | single write-through beat; update the cached word on a hit
//  RESP   | one unstalled cycle so the core retires the access
module dcache_ctrl
    import dcache_pkg::*;
#(
    parameter int ADDR_W = DC_ADDR_W,
    parameter int DATA_W = DC_DATA_W,
    parameter int LINES  = DC_LINES,
    parameter int WORDS  = DC_WORDS
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    input  logic              cpu_memread,
    input  logic              cpu_memwrite,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              stall,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ready
`ifdef DCACHE_STATS_EN
    ,
    output logic [31:0]       hit_count,
    output logic [31:0]       miss_count
`endif
);

    localparam int OFF_W = $clog2(WORDS);
    localparam int IDX_W = $clog2(LINES);
    localparam int TAG_W = ADDR_W - IDX_W - OFF_W - 2;

    state_t              state_q, state_d;
    logic [OFF_W-1:0]    cnt_q, cnt_d;
    logic [ADDR_W-3:0]   lat_addr_q;
    logic [DATA_W-1:0]   lat_wdata_q;
    logic                lat_load;

    logic [TAG_W-1:0]    cpu_tag, lat_tag, cmp_tag, rd_tag;
    logic [IDX_W-1:0]    cpu_idx, lat_idx, rd_idx;
    logic [OFF_W-1:0]    cpu_word, lat_word;
    logic                rd_valid, hit;
    logic [DATA_W-1:0]   rd_data;

    logic                word_we, tag_we;
    logic [OFF_W-1:0]    wr_word;
    logic [DATA_W-1:0]   wr_data;

    assign cpu_word = OFF_W'(addr_field(64'(cpu_addr), FLD_WORD,  OFF_W, IDX_W));
    assign cpu_idx  = IDX_W'(addr_field(64'(cpu_addr), FLD_INDEX, OFF_W, IDX_W));
    assign cpu_tag  = TAG_W'(addr_field(64'(cpu_addr), FLD_TAG,   OFF_W, IDX_W));

    assign lat_word = lat_addr_q[OFF_W-1:0];
    assign lat_idx  = lat_addr_q[OFF_W +: IDX_W];
    assign lat_tag  = lat_addr_q[ADDR_W-3 -: TAG_W];

    // During a store the hit test must use the latched address, not whatever the core presents.
    assign rd_idx  = (state_q == ST_WRITE) ? lat_idx : cpu_idx;
    assign cmp_tag = (state_q == ST_WRITE) ? lat_tag : cpu_tag;
    assign hit     = rd_valid && (rd_tag == cmp_tag);

    assign cpu_rdata = hit ? rd_data : '0;

    dcache_array #(
        .LINES  (LINES),
        .WORDS  (WORDS),
        .TAG_W  (TAG_W),
        .DATA_W (DATA_W)
    ) u_array (
        .clk       (clk),
        .rst_n     (rst_n),
        .rd_index  (rd_idx),
        .rd_word   (cpu_word),
        .rd_tag    (rd_tag),
        .rd_valid  (rd_valid),
        .rd_data   (rd_data),
        .word_we   (word_we),
        .wr_index  (lat_idx),
        .wr_word   (wr_word),
        .wr_data   (wr_data),
        .tag_we    (tag_we),
        .tag_index (lat_idx),
        .tag_wdata (lat_tag)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            lat_addr_q  <= '0;
            lat_wdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (lat_load) begin
                lat_addr_q  <= cpu_addr[ADDR_W-1:2];
                lat_wdata_q <= cpu_wdata;
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        lat_load  = 1'b0;
        stall     = 1'b0;
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        word_we   = 1'b0;
        tag_we    = 1'b0;
        wr_word   = cnt_q;
        wr_data   = mem_rdata;
        case (state_q)
            ST_IDLE: begin
                if (cpu_memwrite) begin
                    stall    = 1'b1;
                    lat_load = 1'b1;
                    state_d  = ST_WRITE;
                end else if (cpu_memread && !hit) begin
                    stall    = 1'b1;
                    lat_load = 1'b1;
                    cnt_d    = '0;
                    state_d  = ST_REFILL;
                end
            end
            ST_REFILL: begin
                stall    = 1'b1;
                mem_req  = 1'b1;
                mem_addr = {lat_addr_q[ADDR_W-3:OFF_W], cnt_q, 2'b00};
                if (mem_ready) begin
                    word_we = 1'b1;
                    cnt_d   = cnt_q + 1'b1;
                    // Valid only goes up with the last word, so a half-filled line never hits.
                    if (cnt_q == OFF_W'(WORDS - 1)) begin
                        tag_we  = 1'b1;
                        state_d = ST_RESP;
                    end
                end
            end
            ST_WRITE: begin
                stall     = 1'b1;
                mem_req   = 1'b1;
                mem_we    = 1'b1;
                mem_addr  = {lat_addr_q, 2'b00};
                mem_wdata = lat_wdata_q;
                if (mem_ready) begin
                    state_d = ST_RESP;
                    if (hit) begin
                        word_we = 1'b1;
                        wr_word = lat_word;
                        wr_data = lat_wdata_q;
                    end
                end
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

`ifdef DCACHE_STATS_EN
    logic count_hit, count_miss;

    assign count_hit  = (state_q == ST_IDLE) && cpu_memread && !cpu_memwrite && hit;
    assign count_miss = (state_q == ST_IDLE) && (cpu_memwrite || (cpu_memread && !hit));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hit_count  <= '0;
            miss_count <= '0;
        end else begin
            if (count_hit && (hit_count != '1)) begin
                hit_count <= hit_count + 32'd1;
            end
            if (count_miss && (miss_count != '1)) begin
                miss_count <= miss_count + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_dcache_ctrl.sv
// Directed self-checking bench for dcache_ctrl with a simple word-addressed memory model.
module tb_dcache_ctrl;

    logic        clk;
    logic        rst_n;
    logic [31:0] cpu_addr;
    logic [31:0] cpu_wdata;
    logic        cpu_memread;
    logic        cpu_memwrite;
    logic [31:0] cpu_rdata;
    logic        stall;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_ready;
`ifdef DCACHE_STATS_EN
    logic [31:0] hit_count;
    logic [31:0] miss_count;
`endif

    int checks = 0;
    int errors = 0;

    dcache_ctrl dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .cpu_addr     (cpu_addr),
        .cpu_wdata    (cpu_wdata),
        .cpu_memread  (cpu_memread),
        .cpu_memwrite (cpu_memwrite),
        .cpu_rdata    (cpu_rdata),
        .stall        (stall),
        .mem_req      (mem_req),
        .mem_we       (mem_we),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .mem_rdata    (mem_rdata),
        .mem_ready    (mem_ready)
`ifdef DCACHE_STATS_EN
        ,
        .hit_count    (hit_count),
        .miss_count   (miss_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory: word i holds 0xC0DE0000 + byte address until written.
    logic [31:0] mem [0:4095];
    int          wait_n = 0;
    int          wcnt;
    assign mem_ready = (wcnt == wait_n);
    assign mem_rdata = mem[mem_addr[13:2]];

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wcnt <= 0;
        end else if (mem_req && !mem_ready) begin
            wcnt <= wcnt + 1;
        end else begin
            wcnt <= 0;
        end
    end

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 4096; i++) mem[i] <= 32'hC0DE0000 + 32'(i * 4);
        end else if (mem_req && mem_ready && mem_we) begin
            mem[mem_addr[13:2]] <= mem_wdata;
        end
    end

    logic [31:0] beat_addr  [$];
    logic        beat_we    [$];
    logic [31:0] beat_wdata [$];
    logic        prev_wait = 1'b0;
    logic [31:0] prev_addr = '0;
    int          stab_err = 0;
    int          wait_seen = 0;

    always @(posedge clk) begin
        if (rst_n && mem_req && mem_ready) begin
            beat_addr.push_back(mem_addr);
            beat_we.push_back(mem_we);
            beat_wdata.push_back(mem_wdata);
        end
        if (rst_n && mem_req && prev_wait && (mem_addr !== prev_addr)) stab_err++;
        if (rst_n && mem_req && !mem_ready) wait_seen++;
        prev_wait = rst_n && mem_req && !mem_ready;
        prev_addr = mem_addr;
    end

    // mode 0 = load, 1 = store, 2 = both asserted
    task automatic do_op(input int mode, input logic [31:0] addr, input logic [31:0] wdata,
                         output int stalls, output logic [31:0] rdata,
                         output int b0, output int beats);
        @(negedge clk);
        cpu_addr     = addr;
        cpu_wdata    = wdata;
        cpu_memread  = (mode != 1);
        cpu_memwrite = (mode != 0);
        b0           = beat_addr.size();
        stalls       = 0;
        #1;
        while (stall && stalls < 200) begin
            stalls++;
            @(negedge clk);
            #1;
        end
        if (stalls >= 200) begin
            errors++;
            $display("FAIL op_timeout: stall still high after %0d cycles, required low", stalls);
        end
        rdata = cpu_rdata;
        @(posedge clk);
        #1;
        beats        = beat_addr.size() - b0;
        cpu_memread  = 1'b0;
        cpu_memwrite = 1'b0;
    endtask

    task automatic test_reset();
        #1;
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL reset_stall: got %b expected 0", stall); end
        checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL reset_mem_req: got %b expected 0", mem_req); end
        checks++; if (mem_we !== 1'b0) begin errors++; $display("FAIL reset_mem_we: got %b expected 0", mem_we); end
        checks++; if (mem_addr !== 32'h0) begin errors++; $display("FAIL reset_mem_addr: got %h expected 0", mem_addr); end
        checks++; if (mem_wdata !== 32'h0) begin errors++; $display("FAIL reset_mem_wdata: got %h expected 0", mem_wdata); end
        checks++; if (cpu_rdata !== 32'h0) begin errors++; $display("FAIL reset_cpu_rdata: got %h expected 0", cpu_rdata); end
`ifdef DCACHE_STATS_EN
        checks++; if (hit_count !== 32'h0) begin errors++; $display("FAIL reset_hit_count: got %0d expected 0", hit_count); end
        checks++; if (miss_count !== 32'h0) begin errors++; $display("FAIL reset_miss_count: got %0d expected 0", miss_count); end
`endif
    endtask

    task automatic test_cold_read();
        int st, b0, nb;
        logic [31:0] rd;
        logic [31:0] exp_a [4];
        exp_a[0] = 32'h40; exp_a[1] = 32'h44; exp_a[2] = 32'h48; exp_a[3] = 32'h4C;
        do_op(0, 32'h40, 32'h0, st, rd, b0, nb);
        checks++; if (st !== 5) begin errors++; $display("FAIL cold_stall: got %0d expected 5", st); end
        checks++; if (rd !== 32'hC0DE0040) begin errors++; $display("FAIL cold_rdata: got %h expected C0DE0040", rd); end
        checks++; if (nb !== 4) begin errors++; $display("FAIL cold_beats: got %0d expected 4", nb); end
        for (int k = 0; k < 4 && k < nb; k++) begin
            checks++;
            if (beat_addr[b0+k] !== exp_a[k] || beat_we[b0+k] !== 1'b0) begin
                errors++;
                $display("FAIL cold_beat%0d: got addr %h we %b expected addr %h we 0", k, beat_addr[b0+k], beat_we[b0+k], exp_a[k]);
            end
        end
        do_op(0, 32'h48, 32'h0, st, rd, b0, nb);
        checks++; if (st !== 0 || nb !== 0) begin errors++; $display("FAIL hit48_stall: got %0d stalls %0d beats expected 0 0", st, nb); end
        checks++; if (rd !== 32'hC0DE0048) begin errors++; $display("FAIL hit48_rdata: got %h expected C0DE0048", rd); end
    endtask

    task automatic test_store_hit();
        int st, b0, nb;
        logic [31:0] rd;
        do_op(1, 32'h44, 32'hDEADBEEF, st, rd, b0, nb);
        checks++; if (st !== 2) begin errors++; $display("FAIL store_hit_stall: got %0d expected 2", st); end
        checks++; if (nb !== 1) begin errors++; $display("FAIL store_hit_beats: got %0d expected 1", nb); end
        if (nb >= 1) begin
            checks++;
            if (beat_addr[b0] !== 32'h44 || beat_we[b0] !== 1'b1 || beat_wdata[b0] !== 32'hDEADBEEF) begin
                errors++;
                $display("FAIL store_hit_beat: got addr %h we %b data %h expected 44 1 DEADBEEF", beat_addr[b0], beat_we[b0], beat_wdata[b0]);
            end
        end
        do_op(0, 32'h44, 32'h0, st, rd, b0, nb);
        checks++; if (st !== 0) begin errors++; $display("FAIL store_hit_reread_stall: got %0d expected 0", st); end
        checks++; if (rd !== 32'hDEADBEEF) begin errors++; $display("FAIL store_hit_reread: got %h expected DEADBEEF", rd); end
    endtask

    task automatic test_store_miss();
        int st, b0, nb;
        logic [31:0] rd;
        do_op(1, 32'h1000, 32'h12345678, st, rd, b0, nb);
        checks++; if (st !== 2 || nb !== 1) begin errors++; $display("FAIL store_miss_stall: got %0d stalls %0d beats expected 2 1", st, nb); end
        if (nb >= 1) begin
            checks++;
            if (beat_addr[b0] !== 32'h1000 || beat_we[b0] !== 1'b1) begin
                errors++;
                $display("FAIL store_miss_beat: got addr %h we %b expected 1000 1", beat_addr[b0], beat_we[b0]);
            end
        end
        do_op(0, 32'h1000, 32'h0, st, rd, b0, nb);
        checks++; if (st !== 5 || nb !== 4) begin errors++; $display("FAIL no_allocate: got %0d stalls %0d beats expected 5 4", st, nb); end
        checks++; if (rd !== 32'h12345678) begin errors++; $display("FAIL store_miss_reread: got %h expected 12345678", rd); end
    endtask

    task automatic test_conflict();
        int st, b0, nb;
        logic [31:0] rd;
        do_op(0, 32'h140, 32'h0, st, rd, b0, nb);
        checks++; if (st !== 5 || rd !== 32'hC0DE0140) begin errors++; $display("FAIL conflict_140: got %0d stalls data %h expected 5 C0DE0140", st, rd); end
        do_op(0, 32'h40, 32'h0, st, rd, b0, nb);
        checks++; if (st !== 5 || nb !== 4) begin errors++; $display("FAIL conflict_evict: got %0d stalls %0d beats expected 5 4", st, nb); end
        checks++; if (rd !== 32'hC0DE0040) begin errors++; $display("FAIL conflict_rdata: got %h expected C0DE0040", rd); end
        do_op(0, 32'h44, 32'h0, st, rd, b0, nb);
        checks++; if (st !== 0 || rd !== 32'hDEADBEEF) begin errors++; $display("FAIL write_through: got %0d stalls data %h expected 0 DEADBEEF", st, rd); end
    endtask

    task automatic test_both_requests();
        int st, b0, nb;
        logic [31:0] rd;
        do_op(2, 32'h48, 32'hA5A5A5A5, st, rd, b0, nb);
        checks++; if (st !== 2 || nb !== 1) begin errors++; $display("FAIL both_stall: got %0d stalls %0d beats expected 2 1", st, nb); end
        if (nb >= 1) begin
            checks++;
            if (beat_we[b0] !== 1'b1 || beat_addr[b0] !== 32'h48) begin
                errors++;
                $display("FAIL both_beat: got addr %h we %b expected 48 1", beat_addr[b0], beat_we[b0]);
            end
        end
        do_op(0, 32'h48, 32'h0, st, rd, b0, nb);
        checks++; if (st !== 0 || rd !== 32'hA5A5A5A5) begin errors++; $display("FAIL both_reread: got %0d stalls data %h expected 0 A5A5A5A5", st, rd); end
    endtask

    task automatic test_wait_states();
        int st, b0, nb, w0;
        logic [31:0] rd;
        wait_n = 2;
        w0 = wait_seen;
        stab_err = 0;
        do_op(0, 32'h200, 32'h0, st, rd, b0, nb);
        wait_n = 0;
        checks++; if (st !== 13) begin errors++; $display("FAIL wait_penalty: got %0d expected 13", st); end
        checks++; if (rd !== 32'hC0DE0200) begin errors++; $display("FAIL wait_rdata: got %h expected C0DE0200", rd); end
        checks++; if (wait_seen - w0 !== 8) begin errors++; $display("FAIL wait_cycles: got %0d expected 8", wait_seen - w0); end
        checks++; if (stab_err !== 0) begin errors++; $display("FAIL wait_addr_stable: got %0d changes expected 0", stab_err); end
    endtask

    task automatic test_reset_abort();
        int st, b0, nb, base, cyc;
        logic [31:0] rd;
        @(negedge clk);
        cpu_addr    = 32'h300;
        cpu_memread = 1'b1;
        base        = beat_addr.size();
        cyc         = 0;
        while ((beat_addr.size() - base) < 2 && cyc < 50) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        checks++; if (beat_addr.size() - base !== 2) begin errors++; $display("FAIL abort_beats: got %0d expected 2", beat_addr.size() - base); end
        checks++; if (mem_req !== 1'b1) begin errors++; $display("FAIL abort_pre_req: got %b expected 1", mem_req); end
        #2;
        cpu_memread = 1'b0;
        rst_n       = 1'b0;
        #1;
        checks++; if (mem_req !== 1'b0 || mem_addr !== 32'h0) begin errors++; $display("FAIL abort_req_drop: got req %b addr %h expected 0 0", mem_req, mem_addr); end
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL abort_stall: got %b expected 0", stall); end
`ifdef DCACHE_STATS_EN
        checks++; if (hit_count !== 32'h0 || miss_count !== 32'h0) begin errors++; $display("FAIL abort_counters: got %0d %0d expected 0 0", hit_count, miss_count); end
`endif
        @(negedge clk);
        rst_n = 1'b1;
        do_op(0, 32'h300, 32'h0, st, rd, b0, nb);
        checks++; if (st !== 5 || nb !== 4) begin errors++; $display("FAIL abort_refetch: got %0d stalls %0d beats expected 5 4", st, nb); end
        if (nb == 4) begin
            checks++;
            if (beat_addr[b0] !== 32'h300 || beat_addr[b0+3] !== 32'h30C) begin
                errors++;
                $display("FAIL abort_refetch_addr: got %h..%h expected 300..30C", beat_addr[b0], beat_addr[b0+3]);
            end
        end
        checks++; if (rd !== 32'hC0DE0300) begin errors++; $display("FAIL abort_rdata: got %h expected C0DE0300", rd); end
        do_op(0, 32'h304, 32'h0, st, rd, b0, nb);
        checks++; if (st !== 0 || rd !== 32'hC0DE0304) begin errors++; $display("FAIL abort_hit: got %0d stalls data %h expected 0 C0DE0304", st, rd); end
`ifdef DCACHE_STATS_EN
        checks++; if (hit_count !== 32'd1 || miss_count !== 32'd1) begin errors++; $display("FAIL stats_after: got %0d %0d expected 1 1", hit_count, miss_count); end
`endif
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, %0d checks %0d errors", checks, errors);
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n        = 1'b0;
        cpu_addr     = '0;
        cpu_wdata    = '0;
        cpu_memread  = 1'b0;
        cpu_memwrite = 1'b0;
        repeat (3) @(negedge clk);
        test_reset();
        rst_n = 1'b1;
        test_cold_read();
        test_store_hit();
        test_store_miss();
        test_conflict();
        test_both_requests();
        test_wait_states();
        test_reset_abort();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/dcache_ctrl.md
# dcache_ctrl

Direct-mapped, write-through, no-write-allocate data cache controller between the core's memory-access stage and main memory. It consumes the control unit's `Memread`/`Memwrite` and the ALU-computed address. It serves read hits with zero wait states and stalls the core on read misses (4-word line refill) and on every store (write-through). Tag, valid and data storage live inside the block.

## Interface
- `ADDR_W`, 32, byte address width
- `DATA_W`, 32, word width; fixed at 32
- `LINES`, 16, number of cache lines; power of two, at least 2
- `WORDS`, 4, words per line; power of two, at least 2

- `clk` in 1: single clock, rising edge
- `rst_n` in 1: asynchronous, active-low reset
- `cpu_addr` in ADDR_W: byte address; bits [1:0] ignored
- `cpu_wdata` in 32: store data
- `cpu_memread` in 1: load request, held until stall is low
- `cpu_memwrite` in 1: store request, held until stall is low
- `cpu_rdata` out 32: load data, valid when `cpu_memread && !stall`
- `stall` out 1: freezes the pipeline
- `mem_req` out 1: memory beat request
- `mem_we` out 1: 1 = write beat, 0 = read beat
- `mem_addr` out ADDR_W: word-aligned beat address
- `mem_wdata` out 32: write beat data
- `mem_rdata` in 32: read beat data, sampled when the beat completes
- `mem_ready` in 1: completes the current beat

## Operation
- Address split: [1:0] byte, next log2(WORDS) bits word offset, next log2(LINES) bits index, remaining upper bits tag.
- Hit condition: `valid[index] && tag[index] == addr_tag`.
- States: IDLE, REFILL, WRITE, RESP.
- IDLE:
  - Read hit: `stall=0`, `cpu_rdata` comes combinationally from the data array.
  - Read miss: `stall=1`; latch index and tag; clear beat counter; go to REFILL.
  - Any write: `stall=1`; latch address and data; go to WRITE.
  - Neither request: `stall=0`.
  - Both requests together: illegal; the write takes priority.
- REFILL:
  - Drive `mem_req=1`, `mem_we=0`, `mem_addr={tag,index,cnt,2'b00}`.
  - Each beat (`mem_req && mem_ready` at a clock edge) writes `mem_rdata` into word `cnt` and increments `cnt`.
  - On beat WORDS-1: write the tag, set `valid`, go to RESP.
- WRITE:
  - Drive `mem_req=1`, `mem_we=1`, the latched address and `mem_wdata`.
  - On beat completion: if the line hits, update the cached word (no-write-allocate on a miss); go to RESP.
- RESP: `stall=0` for exactly one cycle so the core advances. For a load, `cpu_rdata` is the refilled word. Return to IDLE.
- `stall` is high in REFILL and WRITE. In IDLE it follows the miss/write decode above.
- `mem_req` is low in IDLE and RESP. The beat address and data are stable while `mem_req` is high.
- `valid` is set only on the final refill beat, so a partially filled line is never a hit.

## Timing
- Reset values: state IDLE, all `valid` = 0, `cnt` = 0, `stall` = 0, `mem_req` = 0, `mem_we` = 0, `mem_addr` = 0, `mem_wdata` = 0, `cpu_rdata` = 0 when no hit.
- Read hit: 0 wait cycles.
- Read miss with memory always ready: stall cycles 0–4 (beats in cycles 1–4), data in RESP cycle 5. Each memory wait cycle adds one cycle.
- Store with memory always ready: stall cycles 0–1, RESP in cycle 2.
- `mem_ready` while `mem_req` is low is ignored. Back-to-back beats are allowed, one per cycle.
- `cnt` wraps to 0 after the final beat.
- Reset asserted mid-REFILL or mid-WRITE aborts immediately: the line stays invalid, `mem_req` drops asynchronously, and there is no partial update.

## Configuration
- `DCACHE_STATS_EN` defined: adds outputs `hit_count` and `miss_count`, 32 bits each, saturating and reset to 0.
  - Counted once per request, in IDLE: a read hit increments `hit_count`; a read miss or any store increments `miss_count`.
- Undefined: those ports and counters do not exist; all other behaviour is identical.

## Structure
- `dcache_pkg` holds:
  - the state enum (IDLE/REFILL/WRITE/RESP);
  - localparams for offset, index and tag widths derived from `ADDR_W`/`LINES`/`WORDS`;
  - a function that splits an address into tag, index and word fields.
- Sub-module `dcache_array` holds the tag, valid and data storage.
  - Combinational read port.
  - One word-write port.
  - Tag/valid write strobe.
  - Asynchronous clear of all valid bits.
- The FSM, counter and memory interface stay in `dcache_ctrl`.

## Test plan
- Cold read of 0x40, memory ready every cycle → beats at 0x40, 0x44, 0x48, 0x4C; stall for 5 cycles; `cpu_rdata` = memory word at 0x40; a following read of 0x48 hits with 0 stall.
- Store 0xDEADBEEF to 0x44 after that line is filled → one write beat to 0x44; stall for 2 cycles; a following read of 0x44 hits and returns 0xDEADBEEF.
- Store to uncached 0x1000 → write beat only; a following read of 0x1000 misses (no allocate).
- Conflicting addresses 0x40 and 0x140 (LINES=16, WORDS=4) → the second read refills and evicts; a re-read of 0x40 misses.
- Memory inserts 2 wait cycles per beat → miss penalty 13 cycles; `mem_addr` stable while waiting.
- `rst_n` pulsed low after 2 refill beats → `mem_req` = 0 at once; the re-issued read misses and refills all 4 words; with `DCACHE_STATS_EN`, counters are 0 after reset.
